// File: rtl/counter_run_arbiter.sv
// counter_run_arbiter: round-robin sharing of one external 8-bit loadable
// up-counter between two requesters. A run loads {start,3'b000}, counts up
// to the terminal value and ends with a one-cycle done pulse.
// Optional watchdog: define CTR_TIMEOUT_EN to abort runs stuck in COUNT for
// TIMEOUT_CYCLES cycles and raise a sticky err flag.
module counter_run_arbiter #(
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic [4:0] i_start0,
  input  logic [4:0] i_start1,
  input  logic [7:0] i_term0,
  input  logic [7:0] i_term1,
  input  logic       i_hold,
  input  logic [7:0] i_ctr_value,
  output logic       o_ctr_load,
  output logic [4:0] o_ctr_data,
  output logic       o_ctr_count_up,
  output logic       o_ctr_oe_n,
  output logic       o_done0,
  output logic       o_done1,
  output logic       o_busy,
  output logic       o_gnt_id,
  output logic       o_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

  state_t     r_state;
  logic [4:0] r_ctr_data;     // doubles as the latched start value
  logic [7:0] r_term;
  logic       r_armed0;
  logic       r_armed1;
  logic       r_last;         // last granted id; reset to 1 so req0 wins first
  logic       r_ctr_load;
  logic       r_ctr_count_up;
  logic       r_ctr_oe_n;
  logic       r_done0;
  logic       r_done1;
  logic       r_busy;
  logic       r_gnt_id;

  logic       w_elig0;
  logic       w_elig1;
  logic       w_pick1;
  logic [7:0] w_next_value;
  logic       w_term_hit;
  logic       w_timeout;

  assign w_elig0 = i_req0 & r_armed0;
  assign w_elig1 = i_req1 & r_armed1;
  // Requester 1 wins when it is the only one eligible, or when both are and
  // requester 0 was served last.
  assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);

  // The count enable is registered, so the counter value after this edge is
  // the current value plus the increment already being applied. Comparing
  // that look-ahead value against term stops the counter exactly on term.
  assign w_next_value = i_ctr_value + {7'd0, r_ctr_count_up};
  assign w_term_hit   = (w_next_value == r_term);

`ifdef CTR_TIMEOUT_EN
  logic [8:0] r_wd_cnt;
  logic       r_err;

  assign w_timeout = (r_state == S_COUNT) &&
                     ((int'(r_wd_cnt) + 1) >= TIMEOUT_CYCLES);
  assign o_err     = r_err;

  // Watchdog: counts every COUNT cycle (hold included), sticky err on expiry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd_cnt <= 9'd0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_COUNT) r_wd_cnt <= r_wd_cnt + 9'd1;
      else                    r_wd_cnt <= 9'd0;
      if (w_timeout && !w_term_hit) r_err <= 1'b1;
    end
  end
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign o_err            = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Run FSM with all counter controls and status outputs registered
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_ctr_data     <= 5'd0;
      r_term         <= 8'd0;
      r_armed0       <= 1'b1;
      r_armed1       <= 1'b1;
      r_last         <= 1'b1;
      r_ctr_load     <= 1'b0;
      r_ctr_count_up <= 1'b0;
      r_ctr_oe_n     <= 1'b1;
      r_done0        <= 1'b0;
      r_done1        <= 1'b0;
      r_busy         <= 1'b0;
      r_gnt_id       <= 1'b0;
    end else begin
      r_ctr_load <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_elig0 || w_elig1) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_gnt_id   <= w_pick1;
            r_last     <= w_pick1;
            r_ctr_data <= w_pick1 ? i_start1 : i_start0;
            r_term     <= w_pick1 ? i_term1 : i_term0;
            r_ctr_load <= 1'b1;
          end
        end
        S_LOAD: begin
          // Counter value is only valid from the first COUNT cycle on
          r_state        <= S_COUNT;
          r_ctr_oe_n     <= 1'b0;
          r_ctr_count_up <= 1'b0;
        end
        S_COUNT: begin
          if (w_term_hit || w_timeout) begin
            r_state        <= S_DONE;
            r_ctr_count_up <= 1'b0;
            r_done0        <= ~r_gnt_id;
            r_done1        <= r_gnt_id;
          end else begin
            r_ctr_count_up <= ~i_hold;
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_ctr_oe_n <= 1'b1;
          if (r_gnt_id) r_armed1 <= 1'b0;
          else          r_armed0 <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // A low request re-arms; placed last so a drop during DONE still counts
      if (!i_req0) r_armed0 <= 1'b1;
      if (!i_req1) r_armed1 <= 1'b1;
    end
  end

  assign o_ctr_load     = r_ctr_load;
  assign o_ctr_data     = r_ctr_data;
  assign o_ctr_count_up = r_ctr_count_up;
  assign o_ctr_oe_n     = r_ctr_oe_n;
  assign o_done0        = r_done0;
  assign o_done1        = r_done1;
  assign o_busy         = r_busy;
  assign o_gnt_id       = r_gnt_id;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Testbench for counter_run_arbiter: models the external counter, pushes the
// expected outcome of each run into a queue, and a monitor pops and checks
// whenever a done pulse appears. Timeout run only when CTR_TIMEOUT_EN is set.
module tb_counter_run_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [4:0] start0, start1;
  logic [7:0] term0, term1;
  logic       hold;
  logic [7:0] ctr_value;
  logic       ctr_load;
  logic [4:0] ctr_data;
  logic       ctr_count_up;
  logic       ctr_oe_n;
  logic       done0, done1;
  logic       busy;
  logic       gnt_id;
  logic       err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int id;
    int data;
    int value;
    int ups;
    int lat;
  } exp_t;
  exp_t exp_q[$];

  counter_run_arbiter #(.TIMEOUT_CYCLES(10)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req0         (req0),
    .i_req1         (req1),
    .i_start0       (start0),
    .i_start1       (start1),
    .i_term0        (term0),
    .i_term1        (term1),
    .i_hold         (hold),
    .i_ctr_value    (ctr_value),
    .o_ctr_load     (ctr_load),
    .o_ctr_data     (ctr_data),
    .o_ctr_count_up (ctr_count_up),
    .o_ctr_oe_n     (ctr_oe_n),
    .o_done0        (done0),
    .o_done1        (done1),
    .o_busy         (busy),
    .o_gnt_id       (gnt_id),
    .o_err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ctr_value <= 8'd0;
    else if (ctr_load)     ctr_value <= {ctr_data, 3'b000};
    else if (ctr_count_up) ctr_value <= ctr_value + 8'd1;
  end

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  task automatic push_exp(input int id, input int data, input int value,
                          input int ups, input int lat);
    exp_t e;
    e.id = id; e.data = data; e.value = value; e.ups = ups; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge where done of the given id is high
  task automatic wait_done(input int id, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = (id == 1) ? done1 : done0;
    end
    chk($sformatf("done%0d_within_budget", id), int'(seen), 1);
  endtask

  task automatic wait_load(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      seen = ctr_load;
    end
    chk("load_within_budget", int'(seen), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctr_load"}, int'(ctr_load), 0);
    chk({tag, "_ctr_data"}, int'(ctr_data), 0);
    chk({tag, "_count_up"}, int'(ctr_count_up), 0);
    chk({tag, "_oe_n"},     int'(ctr_oe_n), 1);
    chk({tag, "_done"},     int'({done1, done0}), 0);
    chk({tag, "_busy"},     int'(busy), 0);
    chk({tag, "_gnt_id"},   int'(gnt_id), 0);
    chk({tag, "_err"},      int'(err), 0);
  endtask

  // Monitor: tracks each run from its LOAD cycle and checks it at done
  initial begin
    bit in_run;
    int lat, ups, ld;
    exp_t e;
    in_run = 1'b0; lat = 0; ups = 0; ld = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_run = 1'b0;
      end else begin
        if (in_run) lat++;
        if (in_run && ctr_count_up) ups++;
        if (ctr_load) begin
          chk("load_count_exclusive", int'(ctr_count_up), 0);
          chk("oe_n_high_in_load", int'(ctr_oe_n), 1);
          in_run = 1'b1; lat = 1; ups = 0; ld = int'(ctr_data);
        end
        if (done0 || done1) begin
          chk("done_after_load", int'(in_run), 1);
          chk("single_done", int'(done0 & done1), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            $display("run done: id=%0d data=%0d value=%0d ups=%0d lat=%0d",
                     int'(done1), ld, int'(ctr_value), ups, lat);
            chk("done_id", int'(done1), e.id);
            chk("gnt_id", int'(gnt_id), e.id);
            chk("load_data", ld, e.data);
            chk("final_value", int'(ctr_value), e.value);
            chk("count_up_cycles", ups, e.ups);
            chk("latency", lat, e.lat);
            chk("oe_n_low_in_done", int'(ctr_oe_n), 0);
          end
          in_run = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
    start0 = 5'd0; start1 = 5'd0; term0 = 8'd0; term1 = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single run: 16 -> 20
    start0 = 5'd2; term0 = 8'd20;
    push_exp(0, 2, 20, 4, 7);
    req0 = 1'b1;
    wait_done(0, 50);
    @(negedge clk);
    chk("busy_low_after_run", int'(busy), 0);
    req0 = 1'b0;
    @(negedge clk);

    // Zero-length run: start 8 equals term 8
    start0 = 5'd1; term0 = 8'd8;
    push_exp(0, 1, 8, 0, 3);
    req0 = 1'b1;
    wait_done(0, 50);
    // Holding req high after done must not re-grant
    repeat (6) begin
      @(negedge clk);
      chk("no_regrant_busy", int'(busy), 0);
    end
    req0 = 1'b0;
    @(negedge clk);

    // Wrap-around run 248 -> 3; req drop and input changes mid-run ignored
    start1 = 5'd31; term1 = 8'd3;
    push_exp(1, 31, 3, 11, 14);
    req1 = 1'b1;
    repeat (4) @(negedge clk);
    req1 = 1'b0; start1 = 5'd5; term1 = 8'd99;
    wait_done(1, 50);
    @(negedge clk);

    // Contention: both held, alternating 0,1,0,1
    start0 = 5'd0; term0 = 8'd3;
    start1 = 5'd4; term1 = 8'd34;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(0, 0, 3, 3, 6);
      else            push_exp(1, 4, 34, 2, 5);
    end
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(k % 2, 50);
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end else begin
        @(negedge clk);
        if (k % 2 == 0) req0 = 1'b0; else req1 = 1'b0;
        @(negedge clk);
        if (k % 2 == 0) req0 = 1'b1; else req1 = 1'b1;
      end
    end
    repeat (3) @(negedge clk);
    chk("idle_after_contention", int'(busy), 0);

    // Hold for 5 COUNT cycles, then asynchronous reset mid-COUNT
    start0 = 5'd0; term0 = 8'd50; hold = 1'b1;
    req0 = 1'b1;
    wait_load(20);
    repeat (5) begin
      @(negedge clk);
      chk("hold_count_up_low", int'(ctr_count_up), 0);
      chk("hold_busy", int'(busy), 1);
      chk("hold_oe_n_low", int'(ctr_oe_n), 0);
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    req0 = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", int'({done1, done0}), 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef CTR_TIMEOUT_EN
    // Watchdog: hold throughout, abort after 10 COUNT cycles
    start1 = 5'd0; term1 = 8'd9; hold = 1'b1;
    push_exp(1, 0, 0, 0, 12);
    req1 = 1'b1;
    wait_done(1, 50);
    chk("err_set_at_timeout", int'(err), 1);
    req1 = 1'b0; hold = 1'b0;
    repeat (5) @(negedge clk);
    chk("err_sticky", int'(err), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("err_cleared_by_reset", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("all_runs_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_run_arbiter.md
Name: counter_run_arbiter

Overview:
- Round-robin controller that shares one 8-bit loadable up-counter between two requesters.
- Each requester asks for a "run": load a coarse start value, count up to a terminal value, then receive a done pulse.
- Drives the counter's load, count-enable and active-low output-enable controls and its 5-bit load data.
- Watches the counter's 8-bit value to detect the terminal count.

Parameters:
- TIMEOUT_CYCLES, 300: watchdog limit in COUNT cycles. Used only when CTR_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset
- req0, req1  input  1 each  run request level; hold high until done
- start0, start1  input  5 each  start value; counter loads {startN,3'b000}
- term0, term1  input  8 each  terminal count value
- hold  input  1  pauses counting while high
- ctr_value  input  8  current counter value
- ctr_load  output  1  counter load strobe
- ctr_data  output  5  load data to counter
- ctr_count_up  output  1  counter increment enable
- ctr_oe_n  output  1  counter output enable, active low
- done0, done1  output  1 each  one-cycle run-complete pulse
- busy  output  1  high whenever the state is not IDLE
- gnt_id  output  1  id of the current or last granted requester
- err  output  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - ctr_load=0, ctr_data=0, ctr_count_up=0, ctr_oe_n=1.
  - done0=done1=0, busy=0, gnt_id=0, err=0.
  - Both requesters armed; round-robin pointer favours req0.
- Reset mid-run aborts the run immediately. No done pulse is issued.
- States: IDLE, LOAD, COUNT, DONE.
- All control outputs are registered: they change only on clk edges and reflect the current state.
- IDLE:
  - Eligible = reqN high AND armedN.
  - If both are eligible, grant the one not granted last; the first grant after reset goes to req0.
  - On grant: latch startN/termN into internal registers, set gnt_id, go to LOAD.
  - No eligible request: stay in IDLE.
- LOAD (1 cycle): ctr_load=1, ctr_data=latched start. The counter holds {start,3'b000} after this edge. Go to COUNT.
- COUNT:
  - ctr_oe_n=0.
  - If ctr_value == latched term: ctr_count_up=0, go to DONE.
  - Else: ctr_count_up = ~hold.
  - Count cycles with hold=0 equal (term - start*8) mod 256, using 8-bit wrap 255->0.
  - term == start*8 gives zero count cycles: the first COUNT cycle goes straight to DONE.
- DONE (1 cycle):
  - doneN=1 for the granted requester.
  - ctr_oe_n=0; ctr_value stays frozen at term.
  - armedN cleared. Go to IDLE.
- Re-arm: armedN sets again when reqN is sampled low. A requester that holds req high after done is not re-granted.
- ctr_load and ctr_count_up are never both high.
- ctr_oe_n is high in IDLE and LOAD.
- Latency, grant edge to done, with hold=0: 1 (LOAD) + N+1 (COUNT) + done cycle. For N=0, done is high in the 3rd cycle after leaving IDLE.
- Changes to startN/termN during a run have no effect.
- A req drop mid-run is ignored; the run completes.

Optional Feature:
- Macro: CTR_TIMEOUT_EN.
- Defined:
  - A 9-bit cycle counter clears on entry to COUNT and increments every COUNT cycle, including hold cycles.
  - Reaching TIMEOUT_CYCLES without a term match: set err (sticky until reset), force ctr_count_up=0, go to DONE. The done pulse is still issued.
- Undefined: no watchdog; err is tied to 0; hold may stall COUNT indefinitely.

Test Plan:
- Single run: req0=1, start0=2, term0=20, hold=0 -> LOAD drives ctr_data=2; ctr_count_up high for exactly 4 cycles (16->20); done0 pulses once; busy returns low.
- Wrap-around: req1, start1=31 (248), term1=3 -> 11 count cycles (248..255, 0..3); done1 pulses; ctr_value=3.
- Zero-length run: start0=1, term0=8 -> no ctr_count_up cycles; done0 arrives 3 cycles after grant.
- Contention fairness: req0 and req1 high together and held, each dropping req for 1 cycle after its done -> grants alternate 0,1,0,1; no done without a preceding LOAD.
- Hold plus reset: hold=1 for 5 COUNT cycles -> ctr_count_up low and state stays COUNT; then rst_n=0 mid-COUNT -> outputs at reset values immediately, no done pulse.
- Timeout (CTR_TIMEOUT_EN, TIMEOUT_CYCLES=10): hold=1 throughout -> after 10 COUNT cycles err=1, doneN pulses, err stays 1 until reset.
